dadd_apb_master: RTL and testbench
==================================

Name: dadd_apb_master

Overview:
- APB3-style initiator that turns single-word commands from a simple valid/ready port into APB transfers.
- Drives the dadd register file (and any other APB responder on the same bus) from the control side. It replaces bench-only APB driving for integration tests and for the on-chip sequencer.
- One outstanding transfer at a time. Includes wait-state support and a timeout abort.

Parameters:
- APB_AWIDTH, 32, address width of paddr and cmd_addr.
- APB_DWIDTH, 32, data width of pwdata, prdata, cmd_wdata and rsp_rdata.
- TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles with pready low before the transfer is aborted. The value 0 disables the timeout.

Ports:
- pclk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  APB_AWIDTH  target address.
- cmd_wdata  input  APB_DWIDTH  write data.
- rsp_valid  output  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  output  APB_DWIDTH  read data; 0 for writes and on timeout.
- rsp_timeout  output  1  qualifies rsp_valid: the transfer was aborted.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  APB_AWIDTH  APB address.
- pwdata  output  APB_DWIDTH  APB write data.
- pready  input  1  responder ready; wait states allowed.
- prdata  input  APB_DWIDTH  responder read data, sampled in ACCESS when pready=1.

Behaviour:
- Clocking and reset: one clock, pclk. Reset is asynchronous and active-low on rst_n.
- All outputs are registered, except cmd_ready, which is decoded from state.
- Reset values: state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, wait counter=0.
- Reset asserted mid-transfer: psel and penable drop immediately (asynchronously). No rsp_valid is issued for the lost transfer.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1.
  - On accept, capture cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata and go to SETUP.
- SETUP:
  - psel=1, penable=0, cmd_ready=0.
  - Always go to ACCESS next cycle.
- ACCESS:
  - psel=1, penable=1.
  - pready=1: complete the transfer and go to IDLE. In the next cycle rsp_valid=1, rsp_timeout=0, and rsp_rdata = pwrite ? 0 : prdata.
  - pready=0: stay in ACCESS and increment the wait counter.
  - Timeout: if TIMEOUT_CYCLES!=0 and the wait counter reaches TIMEOUT_CYCLES-1 with pready still 0, go to IDLE. In the next cycle rsp_valid=1, rsp_timeout=1, rsp_rdata=0.
  - pready=1 in the same cycle as the timeout threshold: completion wins (normal response).
- Wait counter: cleared on entry to SETUP. Width is clog2(TIMEOUT_CYCLES+1) and it saturates (never wraps).
- Bus hold rules:
  - paddr, pwdata and pwrite are stable from SETUP through the end of ACCESS.
  - After completion they hold their last value; no toggling in IDLE.
- Latency:
  - Accept at edge N → SETUP in cycle N+1 → ACCESS in cycle N+2.
  - Zero-wait completion: rsp_valid in cycle N+3.
  - Each wait state adds 1 cycle.
- Throughput:
  - cmd_ready is high again in the same cycle as rsp_valid, so back-to-back commands issue one transfer every 3 cycles.
  - No ACCESS→SETUP shortcut.
- Command fields are sampled only on accept; later changes are ignored.
- cmd_valid while busy is held off by cmd_ready=0. No command is dropped.

Decomposition:
- Shared header dadd_apb_defines: state encodings (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) and the response-code bit positions.
- Register offsets (DADD_REG_ADDR_OFFSET_0) come from the existing dadd address defines.
- One sub-module: dadd_apb_timeout_cnt. It is a saturating counter with clear, enable and a threshold-hit output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write, zero wait: write cmd addr=DADD_REG_ADDR_OFFSET_0, wdata=0x0000_0023, pready tied 1 → SETUP in cycle +1, ACCESS in cycle +2, rsp_valid in cycle +3 with rsp_rdata=0. The dadd regfile then reports reg_value=0x23 (en=1, addend=0x11).
- Readback: read the same address → rsp_rdata=0x0000_0023, rsp_timeout=0, pwrite=0 throughout.
- Wait states: responder holds pready=0 for 3 ACCESS cycles, then returns prdata=0xA5A5_5A5A → psel/penable/paddr stable for 4 ACCESS cycles; rsp_valid 1 cycle later with rsp_rdata=0xA5A5_5A5A.
- Timeout: TIMEOUT_CYCLES=4, pready stuck at 0 → exactly 4 ACCESS cycles, then psel=0; rsp_valid=1, rsp_timeout=1, rsp_rdata=0. A following command completes normally.
- Back-to-back: cmd_valid held high with 3 writes → 3 transfers with IDLE,SETUP,ACCESS spacing; cmd_ready high only in IDLE; 3 rsp_valid pulses, 3 cycles apart.
- Reset mid-ACCESS: assert rst_n=0 during a wait state → psel, penable and rsp_valid go to 0 asynchronously; after release, state=IDLE and cmd_ready=1.

Source files
------------

// File: rtl/dadd_apb_master_pkg.sv
// Shared definitions for the dadd APB initiator: FSM encoding, response-code
// bit positions, register offsets and the wait-counter width helper.
package dadd_apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_e;

    localparam int unsigned RSP_VALID_BIT   = 0;
    localparam int unsigned RSP_TIMEOUT_BIT = 1;
    localparam int unsigned RSP_CODE_W      = 2;

    localparam logic [31:0] DADD_REG_ADDR_OFFSET_0 = 32'h0000_0010;

    // A disabled timeout still needs a 1-bit counter so the ports stay legal.
    function automatic int unsigned cnt_width(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/dadd_apb_timeout_cnt.sv
// Saturating wait-state counter; hit flags the last permitted wait cycle
// before the initiator aborts the transfer.
module dadd_apb_timeout_cnt
    import dadd_apb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic pclk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] SAT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] THR = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        hit = (TIMEOUT_CYCLES != 0) && (cnt_q == THR);
    end

endmodule

// File: rtl/dadd_apb_master.sv
// APB3 initiator: accepts one valid/ready command at a time, runs a
// SETUP/ACCESS transfer with wait states and a timeout abort.
module dadd_apb_master
    import dadd_apb_master_pkg::*;
#(
    parameter int unsigned APB_AWIDTH     = 32,
    parameter int unsigned APB_DWIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [APB_AWIDTH-1:0] cmd_addr,
    input  logic [APB_DWIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [APB_DWIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_AWIDTH-1:0] paddr,
    output logic [APB_DWIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [APB_DWIDTH-1:0] prdata
);

    apb_state_e                state_q, state_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_AWIDTH-1:0]     paddr_q, paddr_d;
    logic [APB_DWIDTH-1:0]     pwdata_q, pwdata_d;
    logic [RSP_CODE_W-1:0]     rsp_code_q, rsp_code_d;
    logic [APB_DWIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;

    logic accept;
    logic done;
    logic abort;
    logic to_hit;

    dadd_apb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .pclk  (pclk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    ((state_q == ST_ACCESS) && !pready),
        .hit   (to_hit)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_code_q  <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_code_q  <= rsp_code_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Completion beats the timeout when pready rises on the threshold cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cmd_valid) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (pready || to_hit) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // APB strobes are registered from the next state so they switch in step with it.
    always_comb begin
        cmd_ready   = (state_q == ST_IDLE);
        accept      = cmd_ready && cmd_valid;
        done        = (state_q == ST_ACCESS) && pready;
        abort       = (state_q == ST_ACCESS) && !pready && to_hit;

        psel_d      = (state_d != ST_IDLE);
        penable_d   = (state_d == ST_ACCESS);

        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        if (accept) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
        end

        rsp_code_d                  = '0;
        rsp_code_d[RSP_VALID_BIT]   = done || abort;
        rsp_code_d[RSP_TIMEOUT_BIT] = abort;

        rsp_rdata_d = rsp_rdata_q;
        if (done) begin
            rsp_rdata_d = pwrite_q ? '0 : prdata;
        end else if (abort) begin
            rsp_rdata_d = '0;
        end
    end

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_code_q[RSP_VALID_BIT];
    assign rsp_timeout = rsp_code_q[RSP_TIMEOUT_BIT];
    assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_dadd_apb_master.sv
// Directed bench for dadd_apb_master with a small memory-backed APB responder
// whose wait states, stuck-low pready and forced read data are bench-controlled.
module tb_dadd_apb_master;
    import dadd_apb_master_pkg::*;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;

    logic [31:0] mem [16];
    int unsigned acc_cnt = 0;
    int unsigned wait_req;
    logic        stuck;
    logic        rd_force_en;
    logic [31:0] rd_force;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 pclk = ~pclk;

    dadd_apb_master #(
        .APB_AWIDTH     (32),
        .APB_DWIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pready      (pready),
        .prdata      (prdata)
    );

    assign pready = !stuck && (acc_cnt >= wait_req);
    assign prdata = rd_force_en ? rd_force : mem[paddr[5:2]];

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel && penable && pready && pwrite) mem[paddr[5:2]] <= pwdata;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input logic exp_to,
                           input int unsigned exp_acc);
        int unsigned acc;
        int unsigned guard;
        @(negedge pclk);
        chk("idle_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_write = ~wr;
        cmd_addr  = ~addr;
        cmd_wdata = ~wdata;
        chk("setup_sel_en", {30'd0, psel, penable}, 32'd2);
        chk("setup_ready", cmd_ready, 0);
        chk("setup_paddr", paddr, addr);
        chk("setup_pwrite", pwrite, wr);
        if (wr) chk("setup_pwdata", pwdata, wdata);
        acc   = 0;
        guard = 0;
        @(negedge pclk);
        while (psel && guard < 40) begin
            chk("acc_penable", penable, 1);
            chk("acc_paddr", paddr, addr);
            chk("acc_pwrite", pwrite, wr);
            chk("acc_rsp_low", rsp_valid, 0);
            acc++;
            guard++;
            @(negedge pclk);
        end
        chk("acc_cycles", acc, exp_acc);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_timeout", rsp_timeout, exp_to);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_cmd_ready", cmd_ready, 1);
        chk("hold_paddr", paddr, addr);
        @(negedge pclk);
        chk("rsp_pulse", rsp_valid, 0);
        chk("hold_pwrite", pwrite, wr);
    endtask

    logic [31:0] bb_addr [3];
    logic [31:0] bb_data [3];
    int          rsp_t [$];
    int unsigned issued;
    int          d01;
    int          d12;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        wait_req    = 0;
        stuck       = 1'b0;
        rd_force_en = 1'b0;
        rd_force    = '0;

        repeat (2) @(negedge pclk);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        rst_n = 1'b1;

        run_txn(1'b1, DADD_REG_ADDR_OFFSET_0, 32'h0000_0023, 32'h0, 1'b0, 1);
        chk("mem_after_write", mem[DADD_REG_ADDR_OFFSET_0[5:2]], 32'h0000_0023);
        run_txn(1'b0, DADD_REG_ADDR_OFFSET_0, 32'h0, 32'h0000_0023, 1'b0, 1);

        // three waits land on the timeout threshold; completion must win
        wait_req    = 3;
        rd_force_en = 1'b1;
        rd_force    = 32'hA5A5_5A5A;
        run_txn(1'b0, DADD_REG_ADDR_OFFSET_0 + 32'h4, 32'h0, 32'hA5A5_5A5A, 1'b0, 4);
        wait_req    = 0;
        rd_force_en = 1'b0;

        run_txn(1'b1, DADD_REG_ADDR_OFFSET_0, 32'h0000_0055, 32'h0, 1'b0, 1);
        run_txn(1'b0, DADD_REG_ADDR_OFFSET_0, 32'h0, 32'h0000_0055, 1'b0, 1);

        stuck = 1'b1;
        run_txn(1'b0, DADD_REG_ADDR_OFFSET_0, 32'h0, 32'h0, 1'b1, 4);
        stuck = 1'b0;
        run_txn(1'b0, DADD_REG_ADDR_OFFSET_0, 32'h0, 32'h0000_0055, 1'b0, 1);

        bb_addr[0] = DADD_REG_ADDR_OFFSET_0 + 32'h08; bb_data[0] = 32'h1111_0001;
        bb_addr[1] = DADD_REG_ADDR_OFFSET_0 + 32'h0C; bb_data[1] = 32'h2222_0002;
        bb_addr[2] = DADD_REG_ADDR_OFFSET_0 + 32'h14; bb_data[2] = 32'h3333_0003;
        @(negedge pclk);
        issued    = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = bb_addr[0];
        cmd_wdata = bb_data[0];
        for (int t = 0; t < 14; t++) begin
            chk("b2b_ready_idle", cmd_ready, !psel);
            if (rsp_valid) rsp_t.push_back(t);
            if (psel && !penable) begin
                issued++;
                if (issued < 3) begin
                    cmd_addr  = bb_addr[issued];
                    cmd_wdata = bb_data[issued];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            @(negedge pclk);
        end
        d01 = 0;
        d12 = 0;
        if (rsp_t.size() >= 3) begin
            d01 = rsp_t[1] - rsp_t[0];
            d12 = rsp_t[2] - rsp_t[1];
        end
        chk("b2b_issued", issued, 3);
        chk("b2b_rsp_count", rsp_t.size(), 3);
        chk("b2b_gap01", d01, 3);
        chk("b2b_gap12", d12, 3);
        for (int k = 0; k < 3; k++) begin
            run_txn(1'b0, bb_addr[k], 32'h0, bb_data[k], 1'b0, 1);
        end

        stuck = 1'b1;
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = DADD_REG_ADDR_OFFSET_0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        chk("mid_access_penable", penable, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_psel", psel, 0);
        chk("arst_penable", penable, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_cmd_ready", cmd_ready, 1);
        @(negedge pclk);
        rst_n = 1'b1;
        stuck = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge pclk);
            chk("post_rst_rsp", rsp_valid, 0);
            chk("post_rst_psel", psel, 0);
            chk("post_rst_ready", cmd_ready, 1);
        end
        run_txn(1'b0, DADD_REG_ADDR_OFFSET_0, 32'h0, 32'h0000_0055, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
